// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the async FIFO.
// Owns the binary read pointer, drives the memory read address, exports the
// registered Gray read pointer to the write domain, generates empty and
// presents a first-word-fall-through output register with a valid/ready
// handshake toward the consumer.
// Optional occupancy outputs (rlevel, ralmost_empty) are enabled by defining
// FIFO_RD_LEVEL_EN; otherwise they are tied off and no level logic exists.
module fifo_rd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int AE_THRESH  = 2
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic [ADDR_WIDTH:0]   rg2_wptr,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic                  dout_ready,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic [ADDR_WIDTH:0]   rptr,
    output logic                  rempty,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic [ADDR_WIDTH:0]   rlevel,
    output logic                  ralmost_empty
);

    logic [ADDR_WIDTH:0]   r_rbin;
    logic [ADDR_WIDTH:0]   r_rptr;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_dout_valid;

    logic [ADDR_WIDTH:0]   w_rgray;
    logic                  w_rempty;
    logic                  w_fetch;
    logic [ADDR_WIDTH:0]   w_rbin_next;

    // Empty compares the live read pointer (not the lagging rptr) so a fetch
    // can never run past the synchronized write pointer.
    assign w_rgray     = r_rbin ^ (r_rbin >> 1);
    assign w_rempty    = (w_rgray == rg2_wptr);
    assign w_fetch     = !w_rempty && (!r_dout_valid || dout_ready);
    assign w_rbin_next = r_rbin + {{ADDR_WIDTH{1'b0}}, w_fetch};

    // Read pointer advance and output register load / drain.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_rbin       <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            r_rbin <= w_rbin_next;
            if (w_fetch) begin
                r_dout       <= rdata;
                r_dout_valid <= 1'b1;
            end else if (dout_ready && r_dout_valid) begin
                r_dout_valid <= 1'b0;
            end
        end
    end

    // Gray read pointer exported to the write domain, one cycle behind rbin.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_rptr <= '0;
        end else begin
            r_rptr <= w_rgray;
        end
    end

    assign raddr      = r_rbin[ADDR_WIDTH-1:0];
    assign rptr       = r_rptr;
    assign rempty     = w_rempty;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;

`ifdef FIFO_RD_LEVEL_EN
    localparam logic [ADDR_WIDTH:0] AE_LIM = (ADDR_WIDTH+1)'(AE_THRESH);

    logic [ADDR_WIDTH:0] w_wbin;
    logic [ADDR_WIDTH:0] w_level_next;
    logic [ADDR_WIDTH:0] r_rlevel;
    logic                r_ralmost_empty;

    // Gray-to-binary of the synchronized write pointer: bit i is the XOR of
    // all Gray bits from the MSB down to i.
    always_comb begin
        w_wbin = '0;
        for (int unsigned i = 0; i <= ADDR_WIDTH; i++) begin
            w_wbin[i] = ^(rg2_wptr >> i);
        end
    end

    assign w_level_next = w_wbin - w_rbin_next;

    // Occupancy and almost-empty flag, registered against the next read pointer.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_rlevel        <= '0;
            r_ralmost_empty <= 1'b1;
        end else begin
            r_rlevel        <= w_level_next;
            r_ralmost_empty <= (w_level_next <= AE_LIM);
        end
    end

    assign rlevel        = r_rlevel;
    assign ralmost_empty = r_ralmost_empty;
`else
    localparam int unused_ae_thresh = AE_THRESH;

    assign rlevel        = '0;
    assign ralmost_empty = 1'b1;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed self-checking bench for fifo_rd_ctrl (DATA_WIDTH=8, ADDR_WIDTH=3).
// Level expectations follow FIFO_RD_LEVEL_EN when it is defined.
module tb_fifo_rd_ctrl;

    logic       rclk;
    logic       rrst_n;
    logic [3:0] rg2_wptr;
    logic [7:0] rdata;
    logic       dout_ready;
    logic [2:0] raddr;
    logic [3:0] rptr;
    logic       rempty;
    logic [7:0] dout;
    logic       dout_valid;
    logic [3:0] rlevel;
    logic       ralmost_empty;

    logic [7:0] mem [8];

    int n_pass;
    int n_total;

    fifo_rd_ctrl #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(3),
        .AE_THRESH (2)
    ) dut (
        .rclk         (rclk),
        .rrst_n       (rrst_n),
        .rg2_wptr     (rg2_wptr),
        .rdata        (rdata),
        .dout_ready   (dout_ready),
        .raddr        (raddr),
        .rptr         (rptr),
        .rempty       (rempty),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .rlevel       (rlevel),
        .ralmost_empty(ralmost_empty)
    );

    // Combinational memory read, as seen by the controller.
    assign rdata = mem[raddr];

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    function automatic logic [3:0] exp_lvl(input int l);
`ifdef FIFO_RD_LEVEL_EN
        return 4'(l);
`else
        return (l == l) ? 4'd0 : 4'd0;
`endif
    endfunction

    function automatic logic exp_ae(input int l);
`ifdef FIFO_RD_LEVEL_EN
        return (l <= 2);
`else
        return (l == l);
`endif
    endfunction

    task automatic do_reset();
        rrst_n = 1'b0;
        tick();
        tick();
        rrst_n = 1'b1;
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        mem[0] = 8'hA5; mem[1] = 8'h11; mem[2] = 8'h22; mem[3] = 8'h33;
        mem[4] = 8'h44; mem[5] = 8'h55; mem[6] = 8'h66; mem[7] = 8'h77;
        rg2_wptr   = 4'b0000;
        dout_ready = 1'b0;
        rrst_n     = 1'b0;
        #2;

        // Reset state
        tick();
        check("rst_raddr", 32'(raddr), 32'd0);
        check("rst_rptr", 32'(rptr), 32'd0);
        check("rst_rempty", 32'(rempty), 32'd1);
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_rlevel", 32'(rlevel), 32'd0);
        check("rst_ae", 32'(ralmost_empty), 32'd1);
        rrst_n = 1'b1;
        tick();
        check("idle_valid", 32'(dout_valid), 32'd0);

        // First word falls through
        rg2_wptr = 4'b0001;
        #1;
        check("w1_rempty_comb", 32'(rempty), 32'd0);
        tick();
        check("w1_dout", 32'(dout), 32'hA5);
        check("w1_valid", 32'(dout_valid), 32'd1);
        check("w1_raddr", 32'(raddr), 32'd1);
        check("w1_rempty", 32'(rempty), 32'd1);
        check("w1_rptr_lag", 32'(rptr), 32'b0000);
        tick();
        check("w1_rptr", 32'(rptr), 32'b0001);
        check("w1_hold_valid", 32'(dout_valid), 32'd1);

        // Backpressure: three written, consumer stalled
        rg2_wptr = 4'b0010;
        #1;
        check("bp_rempty", 32'(rempty), 32'd0);
        tick();
        check("bp_raddr", 32'(raddr), 32'd1);
        check("bp_dout", 32'(dout), 32'hA5);
        check("bp_valid", 32'(dout_valid), 32'd1);
        check("bp_rlevel", 32'(rlevel), 32'(exp_lvl(2)));
        check("bp_ae", 32'(ralmost_empty), 32'(exp_ae(2)));
        dout_ready = 1'b1;
        tick();
        check("bp_a1_raddr", 32'(raddr), 32'd2);
        check("bp_a1_dout", 32'(dout), 32'h11);
        check("bp_a1_valid", 32'(dout_valid), 32'd1);
        tick();
        check("bp_a2_raddr", 32'(raddr), 32'd3);
        check("bp_a2_dout", 32'(dout), 32'h22);
        check("bp_a2_valid", 32'(dout_valid), 32'd1);
        check("bp_a2_rempty", 32'(rempty), 32'd1);
        tick();
        check("bp_a3_valid", 32'(dout_valid), 32'd0);
        check("bp_a3_dout", 32'(dout), 32'h22);
        check("bp_a3_raddr", 32'(raddr), 32'd3);

        // Advance to rbin=7 with the consumer always ready
        rg2_wptr = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("adv_raddr", 32'(raddr), 32'(4 + i));
            check("adv_dout", 32'(dout), 32'(mem[3 + i]));
        end
        check("adv_rempty", 32'(rempty), 32'd1);
        tick();
        check("adv_drain_valid", 32'(dout_valid), 32'd0);

        // Wrap across the address boundary
        rg2_wptr = 4'b1100;
        #1;
        check("wrap_rempty_pre", 32'(rempty), 32'd0);
        tick();
        check("wrap_raddr", 32'(raddr), 32'd0);
        check("wrap_dout", 32'(dout), 32'h77);
        check("wrap_rempty", 32'(rempty), 32'd1);
        check("wrap_rptr_lag", 32'(rptr), 32'b0100);
        tick();
        check("wrap_rptr", 32'(rptr), 32'b1100);
        check("wrap_valid_off", 32'(dout_valid), 32'd0);

        // Full drain from rbin=0 with eight words in memory
        dout_ready = 1'b0;
        rg2_wptr   = 4'b0000;
        do_reset();
        rg2_wptr   = 4'b1100;
        dout_ready = 1'b1;
        #1;
        check("full_rempty", 32'(rempty), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("full_dout", 32'(dout), 32'(mem[k - 1]));
            check("full_valid", 32'(dout_valid), 32'd1);
            check("full_raddr", 32'(raddr), 32'(k % 8));
            check("full_rlevel", 32'(rlevel), 32'(exp_lvl(8 - k)));
            check("full_ae", 32'(ralmost_empty), 32'(exp_ae(8 - k)));
        end
        check("full_end_rempty", 32'(rempty), 32'd1);
        tick();
        check("full_end_valid", 32'(dout_valid), 32'd0);
        check("full_end_rptr", 32'(rptr), 32'b1100);

        // Asynchronous reset with an undelivered word held in dout
        dout_ready = 1'b0;
        rg2_wptr   = 4'b0000;
        do_reset();
        rg2_wptr   = 4'b0101;
        dout_ready = 1'b1;
        for (int k = 1; k <= 5; k++) tick();
        dout_ready = 1'b0;
        check("ar_pre_raddr", 32'(raddr), 32'd5);
        check("ar_pre_dout", 32'(dout), 32'h44);
        check("ar_pre_valid", 32'(dout_valid), 32'd1);
        #2;
        rrst_n = 1'b0;
        #1;
        check("ar_valid", 32'(dout_valid), 32'd0);
        check("ar_dout", 32'(dout), 32'd0);
        check("ar_raddr", 32'(raddr), 32'd0);
        check("ar_rptr", 32'(rptr), 32'd0);
        tick();
        tick();
        check("ar_hold_valid", 32'(dout_valid), 32'd0);
        check("ar_hold_raddr", 32'(raddr), 32'd0);
        rrst_n = 1'b1;
        tick();
        check("ar_rel_dout", 32'(dout), 32'hA5);
        check("ar_rel_raddr", 32'(raddr), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
- Read-domain controller of the async FIFO; mirror stage to the write-side pointer block.
- Consumes the 2-flop-synchronized Gray write pointer and owns the binary read pointer, the read address into the dual-port memory and the Gray read pointer exported to the write domain.
- Generates empty.
- Adds a first-word-fall-through output register with valid/ready handshake toward the downstream consumer (UART TX path).

Parameters:
- DATA_WIDTH, 8, width of memory read data and dout.
- ADDR_WIDTH, 3, memory address width; depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- AE_THRESH, 2, almost-empty threshold in words (used only with the optional feature).

Ports:
- rclk  in  1  read-domain clock; all state on its rising edge.
- rrst_n  in  1  asynchronous active-low reset; asserts immediately, released synchronously to rclk upstream.
- rg2_wptr  in  ADDR_WIDTH+1  Gray write pointer, already double-synchronized into rclk.
- rdata  in  DATA_WIDTH  memory read data; combinational function of raddr, valid in the same cycle.
- dout_ready  in  1  downstream accepts dout this cycle.
- raddr  out  ADDR_WIDTH  memory read address = rbin[ADDR_WIDTH-1:0].
- rptr  out  ADDR_WIDTH+1  registered Gray of rbin, to the write-domain synchronizer.
- rempty  out  1  no unread word in memory.
- dout  out  DATA_WIDTH  output data register.
- dout_valid  out  1  dout holds a word not yet accepted.
- rlevel  out  ADDR_WIDTH+1  memory occupancy in words (optional feature).
- ralmost_empty  out  1  occupancy <= AE_THRESH (optional feature).

Behaviour:
- Reset: rbin=0, rptr=0, dout=0, dout_valid=0, rlevel=0, ralmost_empty=1. rempty then follows its combinational definition; it is 1 when rg2_wptr=0.
- Gray conversion: gray(x) = x ^ (x>>1). Binary write pointer wbin = Gray-to-binary of rg2_wptr (MSB down, XOR prefix).
- rempty is combinational: rempty = (gray(rbin) == rg2_wptr). It uses the current rbin, not the lagging rptr, so a word is never fetched past the write pointer.
- Fetch condition: fetch = !rempty && (!dout_valid || dout_ready).
- On each fetch:
  - dout <= rdata.
  - dout_valid <= 1.
  - rbin <= rbin+1, modulo 2^(ADDR_WIDTH+1); the MSB toggles at the address wrap.
- When dout_ready && dout_valid && rempty: dout_valid <= 0 and dout holds its value.
- When dout_valid && !dout_ready: dout, dout_valid and rbin all hold. Exactly one word is buffered; no overwrite.
- Simultaneous accept and fetch: new word loads in the same cycle. Sustained throughput is 1 word/cycle.
- rptr <= gray(rbin) every cycle. It lags rbin by one cycle, which is conservative for the write-side full check.
- Latency: a word whose Gray pointer update arrives on rg2_wptr at edge N appears on dout/dout_valid after edge N+1, when dout_valid was 0 before.
- rlevel = wbin - rbin, modulo 2^(ADDR_WIDTH+1). Range 0..2^ADDR_WIDTH; it excludes the word held in dout.
- Pointer MSB differs and lower bits are equal means full: rlevel = 2^ADDR_WIDTH, rempty=0.
- rg2_wptr is trusted to change by at most one Gray step per write-clock edge. No checking is done on multi-step jumps after the synchronizer.
- Reset mid-operation clears all state asynchronously, including a valid undelivered dout word; that word is lost by design.

Optional Feature:
- Macro: FIFO_RD_LEVEL_EN.
- Defined:
  - rlevel is registered: rlevel <= wbin - next rbin, one cycle after the pointer change.
  - ralmost_empty <= (next level <= AE_THRESH).
- Undefined:
  - rlevel is tied to 0 and ralmost_empty is tied to 1.
  - No Gray-to-binary logic or subtractor is synthesized.
  - Ports remain present.

Test Plan:
- Reset with rg2_wptr=0000: raddr=0, rptr=0000, rempty=1, dout_valid=0, dout=00, rlevel=0.
- rg2_wptr 0000->0001, rdata=A5, dout_ready=0: after next edge dout=A5, dout_valid=1, raddr=1, rempty=1; rptr=0001 one edge later.
- Backpressure: rg2_wptr=0010 (3 written), dout_ready=0: one fetch only, raddr stays 1, dout holds; rlevel=2 (feature on). dout_ready=1 for 2 cycles: raddr 1->2->3, dout_valid stays 1, then 0 after the third accept.
- Wrap: rbin=7, rg2_wptr=gray(8)=1100: fetch makes raddr=0, rptr=1100 next cycle, rempty=1.
- Full drain: rbin=0, rg2_wptr=1100: rempty=0, rlevel=8. Hold dout_ready=1: 8 words delivered on 8 consecutive cycles, rptr ends 1100, ralmost_empty rises when level<=2.
- Async reset asserted mid-cycle with dout_valid=1, rbin=5: dout_valid, dout, raddr and rptr go 0 without a clock edge and stay 0 until rrst_n is released.
